// File: rtl/line_batch_controller.sv
// line_batch_controller: walks a batch of lines through precompute, fragment and FB write phases.
// Ports: clk, reset_n; start/num_lines/abort/frag_gen_finish in; stage strobes, line_idx, busy, status out.
module line_batch_controller #(
    parameter int CNT_W          = 8,
    parameter int PRECOMP_WAIT   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_lines,
    input  logic             abort,
    input  logic             frag_gen_finish,
    output logic             load_line,
    output logic             rst_Precomputed,
    output logic             en_Precomputed,
    output logic             rst_fragment,
    output logic             start_fragment,
    output logic             FB_WE,
    output logic             en_FB_reg,
    output logic [CNT_W-1:0] line_idx,
    output logic             busy,
    output logic             sys_finish,
    output logic             timeout_err,
    output logic             aborted
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_RST_PRE,
        S_WAIT_PRE,
        S_RST_FRAG,
        S_START_FRAG,
        S_WAIT_FRAG,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [7:0]       PRE_LAST = 8'(PRECOMP_WAIT - 1);
    localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       pre_cnt;
    logic [15:0]      to_cnt;
    logic             take_batch;
    logic             clr_status;
    logic             inc_idx;
    logic             set_to;
    logic             set_ab;

    always_comb begin
        state_n    = state;
        take_batch = 1'b0;
        clr_status = 1'b0;
        inc_idx    = 1'b0;
        set_to     = 1'b0;
        set_ab     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    clr_status = 1'b1;
                    if (num_lines != '0) begin
                        take_batch = 1'b1;
                        state_n    = S_LOAD;
                    end else begin
                        state_n = S_FINISH;
                    end
                end
            end
            S_LOAD:       state_n = S_RST_PRE;
            S_RST_PRE:    state_n = S_WAIT_PRE;
            S_WAIT_PRE: begin
                if (pre_cnt == PRE_LAST) state_n = S_RST_FRAG;
            end
            S_RST_FRAG:   state_n = S_START_FRAG;
            S_START_FRAG: state_n = S_WAIT_FRAG;
            S_WAIT_FRAG: begin
                if (frag_gen_finish) begin
                    state_n = S_NEXT;
                end else if (to_cnt == TO_LAST) begin
                    set_to  = 1'b1;
                    state_n = S_FINISH;
                end
            end
            S_NEXT: begin
                if (line_idx == count_q - ONE) begin
                    state_n = S_FINISH;
                end else begin
                    inc_idx = 1'b1;
                    state_n = S_LOAD;
                end
            end
            S_FINISH:     state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
        // abort outranks line completion and timeout in every busy state
        if (abort && state != S_IDLE) begin
            set_ab  = 1'b1;
            set_to  = 1'b0;
            inc_idx = 1'b0;
            state_n = (state == S_FINISH) ? S_IDLE : S_FINISH;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            line_idx    <= '0;
            count_q     <= '0;
            pre_cnt     <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state <= state_n;
            if (take_batch) begin
                count_q  <= num_lines;
                line_idx <= '0;
            end else if (inc_idx) begin
                line_idx <= line_idx + ONE;
            end
            if (clr_status) begin
                timeout_err <= 1'b0;
                aborted     <= 1'b0;
            end
            if (set_to) timeout_err <= 1'b1;
            if (set_ab) aborted <= 1'b1;
            if (state == S_RST_PRE) begin
                pre_cnt <= '0;
            end else if (state == S_WAIT_PRE) begin
                pre_cnt <= pre_cnt + 8'd1;
            end
            if (state == S_START_FRAG) begin
                to_cnt <= '0;
            end else if (state == S_WAIT_FRAG && !frag_gen_finish) begin
                to_cnt <= to_cnt + 16'd1;
            end
        end
    end

    assign load_line       = (state == S_LOAD);
    assign rst_Precomputed = (state == S_RST_PRE);
    assign en_Precomputed  = (state == S_WAIT_PRE) || (state == S_WAIT_FRAG);
    assign rst_fragment    = (state == S_RST_FRAG);
    assign start_fragment  = (state == S_START_FRAG);
    assign FB_WE           = (state == S_WAIT_FRAG);
    assign en_FB_reg       = (state == S_WAIT_FRAG);
    assign sys_finish      = (state == S_FINISH);
    assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_line_batch_controller.sv
// tb_line_batch_controller: directed batches checked against a line-offset model
// and hand-computed cycle positions of the stage strobes.
`timescale 1ns/1ps
module tb_line_batch_controller;

    localparam int CW = 8;
    localparam int P  = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          man_fin = 1'b0;
    logic          auto_fin = 1'b0;
    logic          frag_gen_finish;
    logic [CW-1:0] num_lines = '0;
    logic          load_line, rst_Precomputed, en_Precomputed;
    logic          rst_fragment, start_fragment, FB_WE, en_FB_reg;
    logic [CW-1:0] line_idx;
    logic          busy, sys_finish, timeout_err, aborted;

    assign frag_gen_finish = man_fin | auto_fin;

    line_batch_controller #(
        .CNT_W(CW), .PRECOMP_WAIT(P), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .num_lines(num_lines), .abort(abort),
        .frag_gen_finish(frag_gen_finish),
        .load_line(load_line), .rst_Precomputed(rst_Precomputed),
        .en_Precomputed(en_Precomputed), .rst_fragment(rst_fragment),
        .start_fragment(start_fragment), .FB_WE(FB_WE),
        .en_FB_reg(en_FB_reg), .line_idx(line_idx), .busy(busy),
        .sys_finish(sys_finish), .timeout_err(timeout_err),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fragment generator stand-in: finishes on the fin_after-th WAIT_FRAG cycle.
    int fin_after = 0;
    int wf_run = 0;
    always @(posedge clk) begin
        #2;
        if (FB_WE) wf_run++;
        else wf_run = 0;
        auto_fin = (fin_after != 0) && FB_WE && (wf_run == fin_after);
    end

    // Model: position of the batch expressed as an offset inside the current line.
    // offset 0 = load, 1 = precompute reset, 2..P+1 = precompute,
    // P+2 = fragment reset, P+3 = fragment start, >= P+4 = fragment wait.
    int m_off = -1;
    int m_n = 0;
    int m_idx = 0;
    bit m_busy = 0, m_fin = 0, m_nx = 0, m_to = 0, m_ab = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_fin = 0; m_nx = 0; m_off = -1;
            m_n = 0; m_idx = 0; m_to = 0; m_ab = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_to = 0; m_ab = 0; m_busy = 1;
                if (num_lines != 0) begin
                    m_n = num_lines; m_idx = 0; m_off = 0;
                end else begin
                    m_fin = 1;
                end
            end
        end else if (m_fin) begin
            m_fin = 0; m_busy = 0;
            if (abort) m_ab = 1;
        end else if (abort) begin
            m_ab = 1; m_fin = 1; m_off = -1; m_nx = 0;
        end else if (m_nx) begin
            m_nx = 0;
            if (m_idx == m_n - 1) m_fin = 1;
            else begin
                m_idx++; m_off = 0;
            end
        end else if (m_off >= P + 4) begin
            if (frag_gen_finish) begin
                m_nx = 1; m_off = -1;
            end else if (m_off - (P + 4) == TO - 1) begin
                m_to = 1; m_fin = 1; m_off = -1;
            end else begin
                m_off++;
            end
        end else begin
            m_off++;
        end
    end

    logic [31:0] exp_v, act_v;
    always @(negedge clk) begin
        exp_v = {m_off == 0, m_off == 1,
                 (m_off >= 2 && m_off <= P + 1) || m_off >= P + 4,
                 m_off == P + 2, m_off == P + 3,
                 m_off >= P + 4, m_off >= P + 4,
                 m_fin, m_busy, m_to, m_ab, 13'd0, 8'(m_idx)};
        act_v = {load_line, rst_Precomputed, en_Precomputed,
                 rst_fragment, start_fragment, FB_WE, en_FB_reg,
                 sys_finish, busy, timeout_err, aborted, 13'd0, line_idx};
        chk("cycle_model", act_v, exp_v);
    end

    // Event monitor: counts and cycle positions of strobes.
    int n_load = 0, n_fb = 0, n_rf = 0, n_fin = 0, n_enp = 0;
    int c_load, c_rp, c_enp, c_rf, c_sf, c_fb, c_next, c_fin, c_idle;
    bit p_enp = 0, p_fb = 0, p_busy = 0, next_pend = 0;
    int q_idx[$];
    int q_gap[$];
    int q_next[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            next_pend = 0; p_enp = 0; p_fb = 0; p_busy = 0;
        end else begin
            if (load_line) begin
                n_load++; c_load = cyc; q_idx.push_back(int'(line_idx));
            end
            if (rst_Precomputed) c_rp = cyc;
            if (en_Precomputed && !FB_WE) begin
                n_enp++;
                if (!p_enp) c_enp = cyc;
            end
            if (rst_fragment) begin
                n_rf++; c_rf = cyc;
            end
            if (start_fragment) c_sf = cyc;
            if (FB_WE) begin
                n_fb++;
                if (!p_fb) c_fb = cyc;
                if (next_pend) begin
                    q_gap.push_back(cyc - c_next); next_pend = 0;
                end
            end
            if (busy && !sys_finish && !load_line && !rst_Precomputed &&
                !en_Precomputed && !rst_fragment && !start_fragment) begin
                c_next = cyc; next_pend = 1; q_next.push_back(cyc);
            end
            if (sys_finish) begin
                n_fin++; c_fin = cyc; next_pend = 0;
            end
            if (!busy && p_busy) c_idle = cyc;
            p_enp = en_Precomputed && !FB_WE;
            p_fb = FB_WE;
            p_busy = busy;
        end
    end

    task automatic wait_idle(input int bud);
        for (int i = 0; i < bud && busy; i++) tick();
        chk("wait_idle", {31'd0, busy}, 32'd0);
        tick();
    endtask

    // Single-line batch, fragment done on the third WAIT_FRAG cycle.
    task automatic one_line(input bit rel);
        int t, bf, be;
        bf = n_fin; be = n_enp;
        fin_after = 3;
        start = 1'b1; num_lines = 8'd1;
        t = cyc;
        if (rel) begin
            #2 reset_n = 1'b1;
        end
        tick();
        start = 1'b0;
        wait_idle(60);
        chk("load_at_T1", c_load, t + 1);
        chk("rstpre_at_T2", c_rp, t + 2);
        chk("enpre_at_T3", c_enp, t + 3);
        chk("enpre_len", n_enp - be, P);
        chk("rstfrag_at_T5", c_rf, t + 3 + P);
        chk("startfrag_at_T6", c_sf, t + 4 + P);
        chk("waitfrag_at_T7", c_fb, t + 5 + P);
        chk("next_at_T10", c_next, t + 10);
        chk("finish_at_T11", c_fin, t + 11);
        chk("idle_at_T12", c_idle, t + 12);
        chk("one_finish", n_fin - bf, 1);
        chk("idx_end", line_idx, 0);
        chk("status_clear", {timeout_err, aborted}, 0);
    endtask

    int bl, bq, bg, bn, bf, bfb, brf, t0;
    int found;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        chk("reset_idle", {busy, line_idx, timeout_err, aborted}, 0);

        one_line(1'b0);

        // three lines, four WAIT_FRAG cycles each
        tick();
        bl = n_load; bq = q_idx.size(); bg = q_gap.size();
        bn = q_next.size(); bf = n_fin;
        fin_after = 4;
        start = 1'b1; num_lines = 8'd3;
        tick();
        start = 1'b0;
        wait_idle(200);
        chk("three_loads", n_load - bl, 3);
        for (int i = 0; i < 3; i++)
            chk("load_idx", q_idx[bq + i], i);
        chk("three_one_fin", n_fin - bf, 1);
        chk("gap_count", q_gap.size() - bg, 2);
        chk("gap0_incl", q_gap[bg] + 1, P + 6);
        chk("gap1_incl", q_gap[bg + 1] + 1, P + 6);
        chk("next_period", q_next[bn + 1] - q_next[bn], 11);

        // timeout with no fragment completion
        tick();
        fin_after = 0;
        bfb = n_fb; bf = n_fin;
        start = 1'b1; num_lines = 8'd1;
        tick();
        start = 1'b0;
        wait_idle(100);
        chk("to_wf_cycles", n_fb - bfb, TO);
        chk("to_err_set", timeout_err, 1);
        chk("to_one_fin", n_fin - bf, 1);
        chk("to_no_abort", aborted, 0);

        // empty batch, also clears the timeout flag
        tick();
        bl = n_load; bfb = n_fb; brf = n_rf;
        start = 1'b1; num_lines = 8'd0;
        t0 = cyc;
        tick();
        start = 1'b0;
        chk("zero_to_clr", timeout_err, 0);
        chk("zero_fin_now", sys_finish, 1);
        wait_idle(10);
        chk("zero_fin_T1", c_fin, t0 + 1);
        chk("zero_no_load", n_load - bl, 0);
        chk("zero_no_fb", n_fb - bfb, 0);
        chk("zero_no_rf", n_rf - brf, 0);

        // abort in WAIT_PRE of the second line of four
        tick();
        fin_after = 2;
        start = 1'b1; num_lines = 8'd4;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (line_idx == 8'd1 && en_Precomputed && !FB_WE) found = 1;
            else tick();
        end
        chk("ab_reach_wp", found, 1);
        brf = n_rf;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_finish_next", sys_finish, 1);
        chk("ab_flag", aborted, 1);
        wait_idle(10);
        chk("ab_no_rstfrag", n_rf - brf, 0);

        // abort together with fragment completion
        fin_after = 0;
        start = 1'b1; num_lines = 8'd2;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (FB_WE) found = 1;
            else tick();
        end
        chk("abf_reach_wf", found, 1);
        tick();
        bn = q_next.size();
        man_fin = 1'b1; abort = 1'b1;
        tick();
        man_fin = 1'b0; abort = 1'b0;
        chk("abf_finish", sys_finish, 1);
        wait_idle(10);
        chk("abf_no_next", q_next.size() - bn, 0);
        chk("abf_flag", aborted, 1);

        // reset pulse mid-batch, start held high while busy
        fin_after = 0;
        start = 1'b1; num_lines = 8'd2;
        tick();
        num_lines = 8'd5;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (FB_WE) found = 1;
            else tick();
        end
        chk("rst_reach_wf", found, 1);
        bf = n_fin;
        #2 reset_n = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_async_zero",
            {load_line, rst_Precomputed, en_Precomputed, rst_fragment,
             start_fragment, FB_WE, en_FB_reg, sys_finish, busy,
             timeout_err, aborted, 13'd0, line_idx}, 0);
        @(posedge clk);
        #1;
        chk("rst_no_finish", n_fin - bf, 0);
        one_line(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
